// File: rtl/dist_uart_framer.sv
// Distance sample to ASCII frame streamer: double-dabble BCD, then digits, CR, LF.
// Optional DIST_FRAMER_ZERO_BLANK_EN: leading zero digits sent as spaces.
module dist_uart_framer #(
  parameter int unsigned NEAR_CM = 5,
  parameter bit          SEND_LF = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] dist_cm,
  input  logic        dist_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        near,
  output logic        frame_done,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_DIG,
    S_CR,
    S_LF
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        near_q, near_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;

  logic [3:0]  nib;
  logic [7:0]  dig_byte;
  logic        fire;

  function automatic logic [35:0] dabble(input logic [35:0] v);
    logic [35:0] t;
    t = v;
    for (int n = 0; n < 5; n++) begin
      if (t[16+4*n +: 4] >= 4'd5)
        t[16+4*n +: 4] = t[16+4*n +: 4] + 4'd3;
    end
    return {t[34:0], 1'b0};
  endfunction

  always_comb begin
    nib = bcd_q[3:0];
    case (idx_q)
      3'd4:    nib = bcd_q[19:16];
      3'd3:    nib = bcd_q[15:12];
      3'd2:    nib = bcd_q[11:8];
      3'd1:    nib = bcd_q[7:4];
      default: nib = bcd_q[3:0];
    endcase
  end

`ifdef DIST_FRAMER_ZERO_BLANK_EN
  logic lead;

  // A digit is blank only if it and every more significant digit are zero.
  always_comb begin
    lead = 1'b0;
    case (idx_q)
      3'd4:    lead = (bcd_q[19:16] == 4'd0);
      3'd3:    lead = (bcd_q[19:12] == 8'd0);
      3'd2:    lead = (bcd_q[19:8] == 12'd0);
      3'd1:    lead = (bcd_q[19:4] == 16'd0);
      default: lead = 1'b0;
    endcase
    dig_byte = lead ? 8'h20 : {4'h3, nib};
  end
`else
  assign dig_byte = {4'h3, nib};
`endif

  always_comb begin
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    unique case (1'b1)
      (state_q == S_DIG): begin
        tx_valid = 1'b1;
        tx_byte  = dig_byte;
      end
      (state_q == S_CR): begin
        tx_valid = 1'b1;
        tx_byte  = 8'h0D;
      end
      (state_q == S_LF): begin
        tx_valid = 1'b1;
        tx_byte  = 8'h0A;
      end
      default: ;
    endcase
  end

  assign fire = tx_valid & tx_ready;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    near_d  = near_q;
    done_d  = 1'b0;
    ovr_d   = dist_valid & (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (dist_valid) begin
          bin_d   = dist_cm;
          bcd_d   = 20'd0;
          cnt_d   = 4'd0;
          near_d  = (32'(dist_cm) <= NEAR_CM);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        {bcd_d, bin_d} = dabble({bcd_q, bin_q});
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          idx_d   = 3'd4;
          state_d = S_DIG;
        end
      end
      S_DIG: begin
        if (fire) begin
          if (idx_q == 3'd0) state_d = S_CR;
          else idx_d = idx_q - 3'd1;
        end
      end
      S_CR: begin
        if (fire) begin
          if (SEND_LF) begin
            state_d = S_LF;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_LF: begin
        if (fire) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bin_q   <= 16'd0;
      bcd_q   <= 20'd0;
      cnt_q   <= 4'd0;
      idx_q   <= 3'd0;
      near_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      near_q  <= near_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign near       = near_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;

endmodule
